// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and constants for the chunked sequential adder.
package seq_chunk_adder_pkg;

  // Operation select encoding on the sub input.
  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Chunk counter width; at least one bit even for a single chunk.
  function automatic int cnt_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_add_chunk.sv
// Combinational N-bit ripple-carry chunk adder built from full-adder cells.
// Also exposes the carry into the top bit so the caller can form signed overflow.
module seq_chunk_adder_add_chunk #(
  parameter int N = 2
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] s_o,
  output logic         c_o,
  output logic         c_msb_o
);

  logic [N:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o     = c[N];
  assign c_msb_o = c[N-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands are added CHUNK bits per
// clock through one shared ripple chunk adder, with valid/ready on both sides.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_out_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = cnt_width(NCH);
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  // Operands and result viewed as an array of chunks, indexed by the counter.
  logic [NCH-1:0][CHUNK-1:0] a_q, a_d;
  logic [NCH-1:0][CHUNK-1:0] b_q, b_d;
  logic [NCH-1:0][CHUNK-1:0] sum_q, sum_d;
  logic                      carry_q, carry_d;
  logic                      c_out_q, c_out_d;
  logic                      ovf_q, ovf_d;
  logic                      zero_q, zero_d;

  logic [CHUNK-1:0]          ch_s;
  logic                      ch_co;
  logic                      ch_cm;

  // The one shared adder always works on the chunk selected by the counter.
  seq_chunk_adder_add_chunk #(
    .N (CHUNK)
  ) u_add_chunk (
    .a_i     (a_q[cnt_q]),
    .b_i     (b_q[cnt_q]),
    .c_i     (carry_q),
    .s_o     (ch_s),
    .c_o     (ch_co),
    .c_msb_o (ch_cm)
  );

  // Next-state and datapath update; everything holds unless a state acts on it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          // Subtract is A + ~B + 1: invert B once here and seed the carry.
          a_d     = a_i;
          b_d     = b_i ^ {WIDTH{sub_i}};
          carry_d = (sub_i == ALU_OP_SUB);
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[cnt_q] = ch_s;
        carry_d      = ch_co;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          c_out_d = ch_co;
          ovf_d   = ch_co ^ ch_cm;
          zero_d  = ~|sum_d;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign sum_o       = sum_q;
  assign c_out_o     = c_out_q;
  assign ovf_o       = ovf_q;
  assign zero_o      = zero_q;

endmodule
